// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - greedy coin payout sequencer driving a three-denomination hopper
// Pays |DATA_in| with the largest available coins, one hopper handshake per coin, then reports the total.
module coin_change_dispenser #(
  parameter int DEN_H   = 10,
  parameter int DEN_M   = 5,
  parameter int DEN_L   = 1,
  parameter int ACK_TMO = 255
) (
  input  logic       clkm,
  input  logic       rstm,
  input  logic       in_RDY,
  input  logic [7:0] DATA_in,
  input  logic [2:0] coin_empty,
  input  logic       hopper_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       out_RDY,
  output logic [7:0] DATA_out,
  output logic       fault,
  output logic       state_cmp
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEL, S_REQ, S_RELEASE, S_REPORT, S_CMP
  } state_t;

  localparam logic [7:0] VAL_H = 8'(DEN_H);
  localparam logic [7:0] VAL_M = 8'(DEN_M);
  localparam logic [7:0] VAL_L = 8'(DEN_L);
  localparam logic [7:0] TMO   = 8'(ACK_TMO);

  state_t     state_q, state_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] total_q, total_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       fault_q, fault_d;

  logic [1:0] pick;
  logic [7:0] sel_val;
  logic [7:0] mag;

  // Zero-valued denominations are never picked so a misconfiguration cannot spin forever.
  always_comb begin
    pick = 2'b00;
    if (VAL_H != 8'd0 && VAL_H <= rem_q && !coin_empty[2]) pick = 2'b01;
    else if (VAL_M != 8'd0 && VAL_M <= rem_q && !coin_empty[1]) pick = 2'b10;
    else if (VAL_L != 8'd0 && VAL_L <= rem_q && !coin_empty[0]) pick = 2'b11;
  end

  always_comb begin
    case (sel_q)
      2'b01:   sel_val = VAL_H;
      2'b10:   sel_val = VAL_M;
      2'b11:   sel_val = VAL_L;
      default: sel_val = 8'd0;
    endcase
  end

  // -128 has no positive 8-bit twin, so it saturates to 127.
  always_comb begin
    if (opnd_q == 8'h80)  mag = 8'd127;
    else if (opnd_q[7])   mag = ~opnd_q + 8'd1;
    else                  mag = opnd_q;
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    rem_d   = rem_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (in_RDY) begin
          opnd_d  = DATA_in;
          rem_d   = 8'd0;
          total_d = 8'd0;
          fault_d = 1'b0;
          sel_d   = 2'b00;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_RDY) begin
          opnd_d = DATA_in;
        end else begin
          rem_d   = mag;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (pick != 2'b00) begin
          sel_d   = pick;
          cnt_d   = TMO;
          state_d = S_REQ;
        end else begin
          if (rem_q != 8'd0) fault_d = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REQ: begin
        if (hopper_ack) begin
          rem_d   = rem_q - sel_val;
          total_d = total_q + sel_val;
          state_d = S_RELEASE;
        end else if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          fault_d = 1'b1;
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RELEASE: begin
        if (!hopper_ack) state_d = S_SEL;
      end
      S_REPORT: begin
        sel_d   = 2'b00;
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkm or posedge rstm) begin
    if (rstm) begin
      state_q <= S_IDLE;
      opnd_q  <= 8'd0;
      rem_q   <= 8'd0;
      total_q <= 8'd0;
      cnt_q   <= 8'd0;
      sel_q   <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
    end
  end

  // The running total doubles as the result; it only changes while dispensing and clears on a new frame.
  assign coin_req  = (state_q == S_REQ);
  assign coin_sel  = (state_q == S_REQ || state_q == S_RELEASE) ? sel_q :
                     (state_q == S_SEL) ? pick : 2'b00;
  assign out_RDY   = (state_q == S_REPORT);
  assign state_cmp = (state_q == S_CMP);
  assign DATA_out  = total_q;
  assign fault     = fault_q;

endmodule

// File: doc/coin_change_dispenser.md
COIN_CHANGE_DISPENSER -- requirements
Module: coin_change_dispenser

Interface
REQ-001 The block SHALL have parameter DEN_H, default 10, meaning the high coin value.
REQ-002 The block SHALL have parameter DEN_M, default 5, meaning the mid coin value.
REQ-003 The block SHALL have parameter DEN_L, default 1, meaning the low coin value.
REQ-004 The block SHALL have parameter ACK_TMO, default 255, meaning the hopper-ack timeout in cycles (1..255).
REQ-005 The block SHALL have port clkm, input, 1 bit: the clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rstm, input, 1 bit: the reset, asynchronous, active-high.
REQ-007 The block SHALL have port in_RDY, input, 1 bit: the request frame strobe from the main controller.
REQ-008 The block SHALL have port DATA_in, input, 8 bits: the signed change amount, valid during in_RDY.
REQ-009 The block SHALL have port coin_empty, input, 3 bits: hopper-empty flags for H, M, L in bit order [2:0].
REQ-010 The block SHALL have port hopper_ack, input, 1 bit: the hopper acknowledge that one coin was ejected.
REQ-011 The block SHALL have port coin_req, output, 1 bit: the eject request to the hopper.
REQ-012 The block SHALL have port coin_sel, output, 2 bits: the denomination select (01=H, 10=M, 11=L, 00=none).
REQ-013 The block SHALL have port out_RDY, output, 1 bit: result-valid pulse.
REQ-014 The block SHALL have port DATA_out, output, 8 bits: the total value dispensed, valid with out_RDY.
REQ-015 The block SHALL have port fault, output, 1 bit: set when the amount was not fully paid out.
REQ-016 The block SHALL have port state_cmp, output, 1 bit: the sub-state complete pulse.

Function
REQ-017 States: IDLE, LOAD, SEL, REQ, RELEASE, REPORT, CMP.
REQ-018 IDLE: on the first sampled in_RDY=1, go to LOAD.
REQ-019 LOAD: register DATA_in every cycle in_RDY=1; on the first sampled in_RDY=0, the last registered value is the operand; go to SEL.
REQ-020 Operand arithmetic: remaining = |operand|; -128 saturates to 127; a 0 operand goes straight to REPORT with DATA_out=0.
REQ-021 SEL: pick the largest denomination with value <= remaining and its coin_empty bit clear; if found, drive coin_sel and go to REQ next cycle.
REQ-022 SEL: if no denomination qualifies and remaining > 0, set fault and go to REPORT.
REQ-023 SEL: if remaining = 0, go to REPORT.
REQ-024 REQ: coin_req=1 with coin_sel stable; the timeout counter loads ACK_TMO on entry and decrements each cycle.
REQ-025 REQ, hopper_ack=1: subtract the denomination from remaining, add it to the dispensed total (8-bit, no wrap since total <= 127), drop coin_req, go to RELEASE.
REQ-026 REQ, counter reaches 0 without ack: drop coin_req, set fault, go to REPORT; the coin is not counted.
REQ-027 RELEASE: coin_req=0; wait for hopper_ack=0, then go to SEL; coin_req low is guaranteed for >= 1 cycle between coins.
REQ-028 REPORT: out_RDY=1 for exactly one cycle, with DATA_out = dispensed total; go to CMP.
REQ-029 CMP: state_cmp=1 for exactly one cycle, the cycle after out_RDY; then go to IDLE. DATA_out and fault hold until the next LOAD.
REQ-030 in_RDY asserted outside IDLE/LOAD SHALL be ignored; a new frame is only accepted from IDLE.
REQ-031 hopper_ack sampled while not in REQ SHALL be ignored; it SHALL NOT change the totals.
REQ-032 coin_empty is sampled only in SEL; a change during REQ does not abort the current coin.
REQ-033 fault SHALL clear on entry to LOAD.
REQ-034 coin_sel SHALL be 00 in IDLE, LOAD, REPORT and CMP.

Reset
REQ-035 rstm=1 SHALL immediately force IDLE and coin_req=0, coin_sel=00, out_RDY=0, state_cmp=0, fault=0, DATA_out=0, with the internal remaining/total/counter cleared.
REQ-036 Reset mid-dispense SHALL abandon the transaction; no resume after release.
REQ-037 After rstm is released, the first edge SHALL be able to accept in_RDY.

Verification
REQ-038 The bench SHALL cover: frame in_RDY 2 cycles with DATA_in 0 then 17, prompt acks -> coins H, M, L, L in order, then out_RDY with DATA_out=17, then state_cmp the next cycle, fault=0.
REQ-039 The bench SHALL cover: DATA_in=-8 (0xF8) -> coins M, L, L, L, DATA_out=8.
REQ-040 The bench SHALL cover: DATA_in=10 with coin_empty=100 -> coins M, M, DATA_out=10; with coin_empty=111 -> no coin_req, fault=1, DATA_out=0.
REQ-041 The bench SHALL cover: DATA_in=6 with hopper_ack withheld -> coin_req high for ACK_TMO cycles then drops, fault=1, DATA_out=0, then out_RDY and state_cmp.
REQ-042 The bench SHALL cover: DATA_in=0 -> out_RDY two cycles after in_RDY falls, DATA_out=0, no coin_req.
REQ-043 The bench SHALL cover: rstm pulse during REQ -> coin_req=0 the same cycle, all outputs zero, and a following DATA_in=5 dispenses a single M coin correctly.
